obsidian_hazard_controller: RTL
===============================

# obsidian_hazard_controller

Pipeline hazard and flush controller for the Obsidian five-stage LEGv8 pipeline. It takes the IF/ID instruction, the ID/EX load/destination fields and EX-stage branch resolution, and drives the pipeline-register write enables, bubble insertion and flush lines. It handles four conditions: load-use stalls, taken-branch squashes, data-memory wait freezes, and pipeline clearing during reset. It also keeps saturating stall and flush event counters for bring-up.

## Interface
- FLUSH_CYCLES, 2: total cycles flush is asserted per taken branch, including the detection cycle; legal range 1..7.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- id_instr  in  32  instruction held in IF_ID[31:0].
- ex_memread  in  1  MemRead control of the instruction in ID/EX (ID_EX[153]).
- ex_rd  in  5  destination register of the instruction in ID/EX (ID_EX[4:0]).
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register load enable.
- id_ex_write  out  1  ID/EX register load enable.
- id_ex_bubble  out  1  force ID_EX[156:149] control bits to zero on the next load.
- if_id_flush  out  1  replace the IF/ID contents with a NOP on the next load.
- state  out  2  current state: 0 RUN, 1 FLUSH, 2 FREEZE.
- stall_cycles  out  16  saturating count of load-use and freeze cycles.
- flush_events  out  16  saturating count of taken-branch events.

## Operation
- Source registers decoded from id_instr[31:21]:
  - Rn = [9:5] is always a source.
  - Rm = [20:16] is a source for opcodes 450, 458, 550, 558, 650, 658, 750 and 758.
  - Rt = [4:0] is a source for the stores 7C0, 5E0 and 7E0.
  - Loads, LSL/LSR and BR use Rn only.
- Register 31 (XZR) never produces a hazard.
- load_use = ex_memread & (ex_rd != 31) & (ex_rd equals any valid source).
- States and transitions:
  - RUN: default state.
    - ex_branch_taken (with mem_busy=0) goes to FLUSH with remaining = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, it stays in RUN.
    - mem_busy goes to FREEZE.
  - FLUSH:
    - While remaining > 0 and mem_busy = 0, remaining decrements each cycle. When it reaches 0 the state returns to RUN.
    - mem_busy holds the counter and state; no transition to FREEZE.
  - FREEZE: returns to RUN in the first cycle mem_busy=0. Outputs in that cycle follow the RUN rules.
- Output priority, evaluated combinationally from current state and inputs:
  1. rst: all write enables 1, id_ex_bubble=1, if_id_flush=1. This clears the pipeline.
  2. mem_busy, in any state: pc_write, if_id_write and id_ex_write all 0; bubble 0; flush 0. The flush is deferred, not lost.
  3. ex_branch_taken in RUN, or any cycle in FLUSH: all write enables 1, id_ex_bubble=1, if_id_flush=1. The PC loads the branch target. load_use is ignored.
  4. load_use in RUN: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1. One bubble is sufficient because the bubble clears ex_memread.
  5. Otherwise: all write enables 1, bubble 0, flush 0.
- Counters:
  - stall_cycles +1 on each cycle with priority 2 or priority 4 active.
  - flush_events +1 on each cycle where ex_branch_taken=1 in RUN and mem_busy=0.
  - Both counters saturate at 16'hFFFF.

## Timing
- Reset values after any rst cycle: state=RUN, remaining=0, stall_cycles=0, flush_events=0.
- Output values during rst follow priority 1.
- Hazard outputs are same-cycle (zero latency). They must settle before the posedge that loads the pipeline registers.
- State, remaining and counters update on posedge.
- A taken branch asserts the flush outputs for exactly FLUSH_CYCLES non-frozen cycles.
- rst asserted mid-FLUSH or mid-FREEZE aborts the sequence; state returns to RUN on the next edge.
- ex_branch_taken asserted during FLUSH does not restart the counter or add to flush_events.

## Test plan
- Load-use stall: ex_memread=1, ex_rd=2, id_instr ADD with Rn=2 (opcode 458). Expect one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then normal flow; stall_cycles=1.
- No hazard on XZR or a non-source register: ex_rd=31 with Rn=31 gives no stall. A load followed by LDUR with Rt=ex_rd and a different Rn gives no stall.
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken pulsed for one cycle. Expect if_id_flush=1 for exactly 2 cycles and state sequence RUN, FLUSH, RUN; flush_events=1.
- Memory freeze: mem_busy high for 3 cycles during FLUSH. Expect all enables 0 for 3 cycles, the flush counter held, then the remaining flush cycle issued; stall_cycles=3.
- Simultaneous events: ex_branch_taken together with load_use gives flush, not stall. mem_busy together with ex_branch_taken gives a freeze, with flush_events unchanged until mem_busy drops.
- Reset mid-flush: rst asserted in the FLUSH state. Expect enables 1, bubble and flush 1 during reset; state=RUN and both counters 0 afterwards.

Source files
------------

// File: rtl/obsidian_hazard_controller.sv
// rtl/obsidian_hazard_controller.sv - load-use stall, branch flush and memory freeze control for the five-stage pipeline
module obsidian_hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [2:0]  remaining;
    logic [2:0]  next_remaining;
    logic        stall_inc;
    logic        flush_inc;

    logic [10:0] opcode;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic        rm_src;
    logic        rt_src;
    logic        load_use;
    logic        unused_instr_bits;

    assign opcode            = id_instr[31:21];
    assign rm                = id_instr[20:16];
    assign rn                = id_instr[9:5];
    assign rt                = id_instr[4:0];
    assign unused_instr_bits = ^id_instr[15:10];

    always_comb begin
        rm_src = 1'b0;
        rt_src = 1'b0;
        case (opcode)
            11'h450, 11'h458, 11'h550, 11'h558,
            11'h650, 11'h658, 11'h750, 11'h758: rm_src = 1'b1;
            11'h7C0, 11'h5E0, 11'h7E0:          rt_src = 1'b1;
            default: ;
        endcase
    end

    // XZR is excluded once via ex_rd, so a source field of 31 can never match
    assign load_use = ex_memread && (ex_rd != 5'd31) &&
                      ((ex_rd == rn) || (rm_src && ex_rd == rm) || (rt_src && ex_rd == rt));

    always_comb begin
        next_state     = cur_state;
        next_remaining = remaining;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_write    = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;

        if (rst) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (mem_busy) begin
            // A pending flush simply holds its count until memory is ready
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            stall_inc   = 1'b1;
            if (cur_state == RUN) begin
                next_state = FREEZE;
            end
        end else if (cur_state == FLUSH) begin
            id_ex_bubble   = 1'b1;
            if_id_flush    = 1'b1;
            next_remaining = (remaining != 3'd0) ? remaining - 3'd1 : 3'd0;
            if (remaining <= 3'd1) begin
                next_state = RUN;
            end
        end else if (ex_branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state     = FLUSH;
                next_remaining = FLUSH_INIT;
            end else begin
                next_state = RUN;
            end
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            next_state   = RUN;
        end else begin
            next_state = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= RUN;
            remaining    <= 3'd0;
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            cur_state <= next_state;
            remaining <= next_remaining;
            if (stall_inc && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush_inc && flush_events != 16'hFFFF) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

    assign state = cur_state;

endmodule
